// File: rtl/fft_input_loader_if.sv
// Sample-in / bank-write bus of the FFT input loader.
// oDROP_CNT exists only when FFT_LOADER_DROP_CNT_EN is defined.
interface fft_input_loader_if #(
  parameter int LOG4_N = 5,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2*LOG4_N-2
);
  logic signed [DATA_W-1:0]   iDATA;
  logic                       iVALID;
  logic                       iCLR;
  logic                       iFFT_DONE;
  logic                       oWE_0;
  logic                       oWE_1;
  logic                       oWE_2;
  logic                       oWE_3;
  logic        [ADDR_W-1:0]   oADDR_WR;
  logic signed [DATA_W-1:0]   oDATA_RE;
  logic signed [DATA_W-1:0]   oDATA_IM;
  logic                       oSTART;
  logic                       oBUSY;
  logic        [2*LOG4_N-1:0] oCNT;
`ifdef FFT_LOADER_DROP_CNT_EN
  logic        [15:0]         oDROP_CNT;
`endif

  modport master (
    output iDATA, iVALID, iCLR, iFFT_DONE,
    input  oWE_0, oWE_1, oWE_2, oWE_3, oADDR_WR, oDATA_RE, oDATA_IM,
    input  oSTART, oBUSY, oCNT
`ifdef FFT_LOADER_DROP_CNT_EN
    , input oDROP_CNT
`endif
  );

  modport slave (
    input  iDATA, iVALID, iCLR, iFFT_DONE,
    output oWE_0, oWE_1, oWE_2, oWE_3, oADDR_WR, oDATA_RE, oDATA_IM,
    output oSTART, oBUSY, oCNT
`ifdef FFT_LOADER_DROP_CNT_EN
    , output oDROP_CNT
`endif
  );
endinterface

// File: rtl/fft_input_loader.sv
// Loads one N-point real frame into 4 RAM banks in base-4 digit-reversed order,
// then strobes oSTART and waits for iFFT_DONE. Option: FFT_LOADER_DROP_CNT_EN.
module fft_input_loader #(
  parameter int LOG4_N = 5,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2*LOG4_N-2
) (
  input logic              iCLK,
  input logic              iRESET,
  fft_input_loader_if.slave bus
);
  localparam int CNT_W = 2*LOG4_N;
  localparam logic [CNT_W-1:0] LAST_IDX = '1;

  typedef enum logic {ST_LOAD, ST_BUSY} state_t;

  state_t                    state_q;
  logic        [CNT_W-1:0]   cnt_q;
  logic        [CNT_W-1:0]   cnt_d;
  logic        [3:0]         we_q;
  logic        [ADDR_W-1:0]  addr_q;
  logic signed [DATA_W-1:0]  data_q;
  logic                      start_pend_q;
  logic                      start_q;
  logic                      busy_q;
  logic                      accept;
  logic        [CNT_W-1:0]   rev_idx;

  function automatic logic [CNT_W-1:0] digit_rev4(input logic [CNT_W-1:0] n);
    logic [CNT_W-1:0] r;
    r = '0;
    for (int i = 0; i < LOG4_N; i++)
      r[2*i +: 2] = n[2*(LOG4_N-1-i) +: 2];
    return r;
  endfunction

  // iCLR outranks a same-cycle sample; nothing is accepted outside LOAD.
  assign accept  = (state_q == ST_LOAD) && bus.iVALID && !bus.iCLR;
  assign rev_idx = digit_rev4(cnt_q);
  assign cnt_d   = cnt_q + 1'b1;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q      <= ST_LOAD;
      cnt_q        <= '0;
      we_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      start_pend_q <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      we_q         <= '0;
      start_pend_q <= 1'b0;
      // oSTART trails the last write by one cycle so the RAM is complete.
      start_q      <= start_pend_q & ~bus.iCLR;
      if (accept) begin
        we_q   <= 4'b0001 << rev_idx[1:0];
        addr_q <= rev_idx[2 +: ADDR_W];
        data_q <= bus.iDATA;
      end
      if (bus.iCLR) begin
        state_q <= ST_LOAD;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else if (accept) begin
        cnt_q <= cnt_d;
        if (cnt_q == LAST_IDX) begin
          state_q      <= ST_BUSY;
          busy_q       <= 1'b1;
          start_pend_q <= 1'b1;
        end
      end else if (state_q == ST_BUSY && bus.iFFT_DONE) begin
        state_q <= ST_LOAD;
        busy_q  <= 1'b0;
      end
    end
  end

`ifdef FFT_LOADER_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      drop_q <= '0;
    end else if (bus.iCLR) begin
      drop_q <= '0;
    end else if (state_q == ST_BUSY && bus.iVALID && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.oDROP_CNT = drop_q;
`endif

  assign bus.oWE_0    = we_q[0];
  assign bus.oWE_1    = we_q[1];
  assign bus.oWE_2    = we_q[2];
  assign bus.oWE_3    = we_q[3];
  assign bus.oADDR_WR = addr_q;
  assign bus.oDATA_RE = data_q;
  assign bus.oDATA_IM = '0;
  assign bus.oSTART   = start_q;
  assign bus.oBUSY    = busy_q;
  assign bus.oCNT     = cnt_q;
endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
Front-end stage of the radix-4 FFT. Captures a stream of real 16-bit samples (no backpressure) and writes one N-point frame into the 4-bank RAM in base-4 digit-reversed order, imaginary part zero. When the frame is complete it pulses a start strobe to the FFT control unit. It then ignores input until the control unit reports completion.

Parameters:
LOG4_N, 5, log4 of frame length; N = 4^LOG4_N (default 1024)
DATA_W, 16, sample and RAM data width
ADDR_W, 2*LOG4_N-2, per-bank RAM address width (default 8)

Ports:
iCLK  in  1  clock
iRESET  in  1  asynchronous reset, active-low
iDATA  in  DATA_W  signed real sample
iVALID  in  1  sample strobe, one sample per high cycle
iCLR  in  1  synchronous frame restart
iFFT_DONE  in  1  one-cycle pulse from FFT control (its oRDY), frame consumed
oWE_0..oWE_3  out  1 each  per-bank write enable, at most one high per cycle
oADDR_WR  out  ADDR_W  write address, shared by all banks
oDATA_RE  out  DATA_W  write data, real part
oDATA_IM  out  DATA_W  write data, imaginary part, always 0
oSTART  out  1  one-cycle pulse: frame loaded, FFT may start
oBUSY  out  1  high while waiting for iFFT_DONE
oCNT  out  2*LOG4_N  samples accepted in the current frame

Behaviour:
- Reset (iRESET low, async): state LOAD; oCNT=0; all oWE_x=0; oADDR_WR=0; oDATA_RE=0; oDATA_IM=0; oSTART=0; oBUSY=0.
- States: LOAD, BUSY.
- LOAD: each cycle with iVALID=1 accepts a sample with index n=oCNT.
  - r = base-4 digit reversal of n over LOG4_N digits.
  - bank = r[1:0]; address = r[2*LOG4_N-1:2].
  - Next cycle (1-cycle registered latency): oWE_bank=1, oADDR_WR=address, oDATA_RE=iDATA, oDATA_IM=0. All other oWE_x=0.
  - oCNT increments on every accepted sample.
- Last sample (n=N-1) accepted:
  - oCNT wraps to 0; state goes to BUSY.
  - oSTART pulses in the cycle after the final write is presented, i.e. 2 cycles after acceptance. This guarantees all data is in RAM before control reads it.
  - oBUSY=1 from the cycle after acceptance.
- BUSY: iVALID samples are dropped (no write, oCNT held). iFFT_DONE=1 returns to LOAD next cycle and clears oBUSY. A sample with iVALID in that same iFFT_DONE cycle is still dropped.
- iFFT_DONE in LOAD: ignored.
- iCLR (any state): next cycle state LOAD, oCNT=0, oBUSY=0.
  - A pending write already registered still completes.
  - A pending oSTART is suppressed.
  - iCLR wins over a simultaneous iVALID: that sample is dropped.
- oWE_x are all 0 in every cycle without an accepted sample in the previous cycle.
- Bank mapping (fixed, shared with control): the bank index is the most-significant base-4 digit of n. Four consecutive addresses across banks hold one radix-4 butterfly group of stage 0.

Optional Feature:
FFT_LOADER_DROP_CNT_EN
- Defined: adds output oDROP_CNT, 16 bits.
  - Increments for each iVALID sample dropped in BUSY.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by iCLR.
  - Samples dropped by iCLR priority are not counted.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset then iVALID with n=1, iDATA=16'h1234 -> next cycle oWE_0=1, oADDR_WR=64, oDATA_RE=16'h1234, oDATA_IM=0.
- Continuous iVALID on n=0..1023 -> n=256 writes bank 1 addr 0; n=4 writes bank 0 addr 16; n=1023 writes bank 3 addr 255. oSTART pulses exactly once, 2 cycles after n=1023; oBUSY=1; oCNT=0.
- In BUSY, 10 iVALID pulses, then iFFT_DONE -> no oWE_x, oCNT stays 0, oDROP_CNT=10 (macro on); next frame's first write goes to bank 0 addr 0.
- iCLR asserted at oCNT=500 together with iVALID -> that sample not written, oCNT=0 next cycle, the following sample n=0 writes bank 0 addr 0.
- iRESET low mid-frame (oCNT=300) -> all outputs 0 immediately, no clock needed; after release, state LOAD with oCNT=0.
- Gapped iVALID (1 of every 3 cycles) for a full frame -> 1024 writes, each 1 cycle after its sample. Never two oWE_x high at once. Single oSTART pulse.
